// File: rtl/rv32_fetch_prefetch.sv
// RV32 instruction-fetch stage: owns the fetch PC, issues word requests on a req/gnt/rvalid
// port, buffers returned words with their PC in a show-ahead FIFO and hands them to decode.
module rv32_fetch_prefetch #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        id_valid_o,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc_o,
    input  logic        id_ready_i
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      resp_pc_q, resp_pc_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    fetch_entry_t     fifo_q [FIFO_DEPTH];

    logic fill_ok_c, grant_c, rsp_c, drop_c, push_c, pop_c;
    logic unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc_i[1:0];

    // Handshake decode; credits cover both buffered and in-flight words so a push never overflows.
    always_comb begin
        fill_ok_c  = (SUM_W'(count_q) + SUM_W'(outst_q)) < SUM_W'(FIFO_DEPTH);
        imem_req_o = !rst_i && !redirect_i && fill_ok_c && (outst_q < CNT_W'(MAX_OUTSTANDING));
        grant_c    = imem_req_o && imem_gnt_i;
        rsp_c      = imem_rvalid_i && (outst_q != '0);
        drop_c     = rsp_c && (discard_q != '0);
        push_c     = rsp_c && !drop_c && !redirect_i;
        pop_c      = (count_q != '0) && id_ready_i && !redirect_i;
    end

    // Next-state: redirect flushes the buffer and marks every in-flight word for discard.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        outst_d    = outst_q + CNT_W'(grant_c) - CNT_W'(rsp_c);
        discard_d  = discard_q;
        if (redirect_i) begin
            fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
            resp_pc_d  = {redirect_pc_i[31:2], 2'b00};
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            discard_d  = outst_d;
        end else begin
            if (grant_c) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (drop_c) begin
                discard_d = discard_q - CNT_W'(1);
            end
            if (push_c) begin
                resp_pc_d = resp_pc_q + 32'd4;
                wr_ptr_d  = wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
        end
    end

    // Payload storage needs no reset: entries are only visible while count is non-zero.
    always_ff @(posedge clk_i) begin
        if (push_c) begin
            fifo_q[wr_ptr_q] <= '{pc: resp_pc_q, instr: imem_rdata_i};
        end
    end

    assign imem_addr_o = fetch_pc_q;
    assign id_valid_o  = (count_q != '0);
    assign id_pc_o     = id_valid_o ? fifo_q[rd_ptr_q].pc    : 32'h0;
    assign id_instr_o  = id_valid_o ? fifo_q[rd_ptr_q].instr : 32'h0;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert ((SUM_W'(count_q) + SUM_W'(outst_q)) <= SUM_W'(FIFO_DEPTH));
            assert (discard_q <= outst_q);
            assert (outst_q <= CNT_W'(MAX_OUTSTANDING));
            assert (id_pc_o[1:0] == 2'b00);
        end
    end

endmodule

// File: tb/tb_rv32_fetch_prefetch.sv
// Bench for rv32_fetch_prefetch: in-order memory responder, queue-based reference model
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_rv32_fetch_prefetch;

    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        id_valid_o;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_o;
    logic        id_ready_i;

    rv32_fetch_prefetch #(
        .RESET_PC        (32'h0000_0000),
        .FIFO_DEPTH      (DEPTH),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .id_valid_o    (id_valid_o),
        .id_instr_o    (id_instr_o),
        .id_pc_o       (id_pc_o),
        .id_ready_i    (id_ready_i)
    );

    always #10 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h13 + (a >> 2);
    endfunction

    // Memory responder: granted addresses return in order, no earlier than 'due'.
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t mem_q[$];
    int    cyc   = 0;
    int    lat   = 1;
    bit    rv_en = 1'b1;

    // Inputs change at the falling edge; the driver inspects outputs 2 time units later.
    task automatic tick(input logic g, input logic r, input logic rd, input logic [31:0] rpc);
        @(negedge clk_i);
        cyc++;
        imem_gnt_i    = g;
        id_ready_i    = r;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        if (rv_en && mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'hDEAD_BEEF;
        end
        #1;
        if (imem_req_o && imem_gnt_i) mem_q.push_back('{addr: imem_addr_o, due: cyc + lat});
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        #1;
        chk("rst_req_now",   32'(imem_req_o), 32'd0);
        chk("rst_valid_now", 32'(id_valid_o), 32'd0);
        chk("rst_pc_now",    id_pc_o,         32'd0);
        chk("rst_instr_now", id_instr_o,      32'd0);
        mem_q.delete();
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        rst_i = 1'b0;
        #1;
        chk("post_rst_req",  32'(imem_req_o), 32'd1);
        chk("post_rst_addr", imem_addr_o,     32'h0);
    endtask

    task automatic wait_valid(input int budget, input logic g, input logic r);
        int n = 0;
        while (id_valid_o !== 1'b1 && n < budget) begin
            tick(g, r, 1'b0, 32'h0);
            n++;
        end
        chk("wait_valid", 32'(id_valid_o), 32'd1);
    endtask

    // Reference model: buffered entries, in-flight and discard counts, PCs.
    logic [31:0] m_fetch = 32'h0;
    logic [31:0] m_resp  = 32'h0;
    int          m_out   = 0;
    int          m_disc  = 0;
    logic [63:0] m_q[$];
    logic        exp_req;
    logic [63:0] exp_head;
    bit          had_out;

    always begin : compare
        @(negedge clk_i);
        #5;
        if (rst_i) begin
            chk("m_rst_req",   32'(imem_req_o), 32'd0);
            chk("m_rst_addr",  imem_addr_o,     32'h0);
            chk("m_rst_valid", 32'(id_valid_o), 32'd0);
            chk("m_rst_pc",    id_pc_o,         32'h0);
            chk("m_rst_instr", id_instr_o,      32'h0);
            m_fetch = 32'h0;
            m_resp  = 32'h0;
            m_out   = 0;
            m_disc  = 0;
            m_q.delete();
        end else begin
            exp_req  = !redirect_i && (m_q.size() + m_out < DEPTH) && (m_out < MAXO);
            exp_head = (m_q.size() != 0) ? m_q[0] : 64'h0;
            chk("m_req",   32'(imem_req_o), 32'(exp_req));
            chk("m_addr",  imem_addr_o,     m_fetch);
            chk("m_valid", 32'(id_valid_o), 32'(m_q.size() != 0));
            chk("m_pc",    id_pc_o,         exp_head[63:32]);
            chk("m_instr", id_instr_o,      exp_head[31:0]);
            if (redirect_i) begin
                if (imem_rvalid_i && m_out > 0) m_out--;
                m_disc  = m_out;
                m_q.delete();
                m_fetch = redirect_pc_i & 32'hFFFF_FFFC;
                m_resp  = m_fetch;
            end else begin
                had_out = (m_out > 0);
                if (m_q.size() != 0 && id_ready_i) void'(m_q.pop_front());
                if (imem_rvalid_i && had_out) begin
                    m_out--;
                    if (m_disc > 0) m_disc--;
                    else begin
                        m_q.push_back({m_resp, imem_rdata_i});
                        m_resp = m_resp + 32'd4;
                    end
                end
                if (exp_req && imem_gnt_i) begin
                    m_fetch = m_fetch + 32'd4;
                    m_out++;
                end
            end
        end
    end

    initial begin
        int grants;
        rst_i = 1'b1;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
        redirect_i = 1'b0; redirect_pc_i = 32'h0; id_ready_i = 1'b0;

        // Reset, then a streaming run at one instruction per cycle.
        do_reset();
        lat = 1;
        for (int k = 0; k < 10; k++) begin
            tick(1'b1, 1'b1, 1'b0, 32'h0);
            if (k >= 2) begin
                chk("stream_valid", 32'(id_valid_o), 32'd1);
                chk("stream_pc",    id_pc_o,         32'((k - 2) * 4));
                chk("stream_instr", id_instr_o,      32'h13 + 32'(k - 2));
            end
        end

        // Backpressure: four credits, then drain and resume at 0x10.
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        do_reset();
        grants = 0;
        for (int k = 0; k < 10; k++) begin
            tick(1'b1, 1'b0, 1'b0, 32'h0);
            if (imem_req_o && imem_gnt_i) grants++;
        end
        chk("bp_grants", 32'(grants),      32'd4);
        chk("bp_req",    32'(imem_req_o),  32'd0);
        chk("bp_head",   id_pc_o,          32'h0);
        for (int j = 0; j < 5; j++) begin
            tick(1'b1, 1'b1, 1'b0, 32'h0);
            chk("drain_pc",    id_pc_o,    32'(j * 4));
            chk("drain_instr", id_instr_o, 32'h13 + 32'(j));
            if (j == 1) chk("resume_addr", imem_addr_o, 32'h10);
        end

        // Back-to-back redirects with two words in flight; last target wins.
        do_reset();
        lat = 3;
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 1'b1, 32'h100);
        chk("redir_req", 32'(imem_req_o), 32'd0);
        tick(1'b1, 1'b0, 1'b1, 32'h203);
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        chk("redir_valid_low", 32'(id_valid_o), 32'd0);
        wait_valid(20, 1'b1, 1'b0);
        chk("redir_pc",    id_pc_o,    32'h200);
        chk("redir_instr", id_instr_o, 32'h93);

        // Redirect in the same cycle as a pop and a response.
        do_reset();
        lat = 2;
        for (int k = 0; k < 5; k++) tick(1'b1, 1'b0, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b1, 32'h400);
        chk("rpop_valid", 32'(id_valid_o),    32'd1);
        chk("rpop_head",  id_pc_o,            32'h0);
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        chk("rpop_flushed", 32'(id_valid_o),  32'd0);
        wait_valid(20, 1'b1, 1'b0);
        chk("rpop_pc",    id_pc_o,    32'h400);
        chk("rpop_instr", id_instr_o, 32'h113);

        // Wait states hold req/addr, then wrap through the top of the address space.
        do_reset();
        lat = 1;
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 1'b1, 1'b0, 32'h0);
            chk("ws_req",  32'(imem_req_o), 32'd1);
            chk("ws_addr", imem_addr_o,     32'h0);
        end
        tick(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
        wait_valid(20, 1'b1, 1'b1);
        chk("wrap_pc0",    id_pc_o,    32'hFFFF_FFF8);
        chk("wrap_instr0", id_instr_o, 32'h4000_0011);
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        chk("wrap_pc1",    id_pc_o,    32'hFFFF_FFFC);
        chk("wrap_instr1", id_instr_o, 32'h4000_0012);
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        chk("wrap_pc2",    id_pc_o,    32'h0);
        chk("wrap_instr2", id_instr_o, 32'h13);

        // Mixed soak under the model: stalls, late responses, occasional redirects.
        for (int k = 0; k < 400; k++) begin
            lat   = int'($urandom_range(1, 3));
            rv_en = ($urandom_range(0, 3) != 0);
            tick(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 31) == 0), $urandom);
        end
        rv_en = 1'b1;
        for (int k = 0; k < 10; k++) tick(1'b0, 1'b1, 1'b0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
